// File: rtl/rf_alu_datapath_pkg.sv
// Shared constants for the register-file/ALU datapath: opcode encodings and
// bit positions of the packed flag register.
package rf_alu_datapath_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOT  = 3'b101;
   localparam logic [2:0] OP_PASS = 3'b110;
   localparam logic [2:0] OP_INC  = 3'b111;

   localparam int FLAG_O = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_W = 3;

endpackage

// File: rtl/rf_alu_datapath_alu.sv
// Combinational N-bit ALU with wrap-around arithmetic and zero/negative/
// signed-overflow flags derived from the result.
module rf_alu_datapath_alu
   import rf_alu_datapath_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   op,
   output logic [N-1:0] r,
   output logic         o,
   output logic         z,
   output logic         n
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   always_comb begin
      r = a;
      o = 1'b0;
      case (op)
         OP_ADD: begin
            r = a + b;
            o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
         end
         OP_SUB: begin
            r = a - b;
            o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOT:  r = ~a;
         OP_PASS: r = a;
         OP_INC: begin
            r = a + ONE;
            // the constant 1 is positive, so only a positive A can overflow
            o = !a[N-1] && r[N-1];
         end
         default: r = a;
      endcase
   end

   assign z = (r == '0);
   assign n = r[N-1];

endmodule

// File: rtl/rf_alu_datapath.sv
// Register file with bypassable read ports feeding the ALU; result and flags
// are registered and the result is gated onto dout by oe.
module rf_alu_datapath
   import rf_alu_datapath_pkg::*;
#(
   parameter int M = 3,
   parameter int N = 8
) (
   input  logic [N-1:0] din,
   input  logic [M-1:0] waddr,
   input  logic [M-1:0] ra,
   input  logic [M-1:0] rb,
   input  logic [2:0]   op,
   input  logic         ie,
   input  logic         write,
   input  logic         reada,
   input  logic         readb,
   input  logic         rst,
   input  logic         clk,
   input  logic         en,
   input  logic         oe,
   input  logic [N-1:0] offset,
   input  logic         bypassa,
   input  logic         bypassb,
   output logic [N-1:0] dout,
   output logic         o_flag,
   output logic         z_flag,
   output logic         n_flag
);

   localparam int REGS = 2**M;

   logic [N-1:0]      rf [REGS];
   logic [N-1:0]      result_reg;
   logic [FLAG_W-1:0] flags;

   logic [N-1:0] a_rf, b_rf, a_op, b_op, alu_r;
   logic         alu_o, alu_z, alu_n;

   assign a_rf = reada ? rf[ra] : '0;
   assign b_rf = readb ? rf[rb] : '0;
   assign a_op = bypassa ? offset : a_rf;
   assign b_op = bypassb ? offset : b_rf;

   rf_alu_datapath_alu #(.N(N)) u_alu (
      .a  (a_op),
      .b  (b_op),
      .op (op),
      .r  (alu_r),
      .o  (alu_o),
      .z  (alu_z),
      .n  (alu_n)
   );

   // writeback sees the pre-edge result_reg even when en loads it this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REGS; i++) rf[i] <= '0;
      end else if (write) begin
         rf[waddr] <= ie ? din : result_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg <= '0;
         flags      <= '0;
      end else if (en) begin
         result_reg     <= alu_r;
         flags[FLAG_O]  <= alu_o;
         flags[FLAG_Z]  <= alu_z;
         flags[FLAG_N]  <= alu_n;
      end
   end

   assign dout   = oe ? result_reg : '0;
   assign o_flag = flags[FLAG_O];
   assign z_flag = flags[FLAG_Z];
   assign n_flag = flags[FLAG_N];

endmodule

// File: tb/tb_rf_alu_datapath.sv
// Directed-vector bench for rf_alu_datapath with hand-computed expectations.
module tb_rf_alu_datapath;
   import rf_alu_datapath_pkg::*;

   localparam int M = 3;
   localparam int N = 8;

   logic [N-1:0] din, offset, dout;
   logic [M-1:0] waddr, ra, rb;
   logic [2:0]   op;
   logic ie, write, reada, readb, rst, clk, en, oe, bypassa, bypassb;
   logic o_flag, z_flag, n_flag;

   int checks = 0;
   int errors = 0;

   rf_alu_datapath #(.M(M), .N(N)) dut (
      .din(din), .waddr(waddr), .ra(ra), .rb(rb), .op(op), .ie(ie),
      .write(write), .reada(reada), .readb(readb), .rst(rst), .clk(clk),
      .en(en), .oe(oe), .offset(offset), .bypassa(bypassa), .bypassb(bypassb),
      .dout(dout), .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // flags packed as {o,z,n}
   task automatic chk_out(input string tag, input logic [N-1:0] exp_d, input logic [2:0] exp_f);
      chk({tag, ".dout"}, 16'(dout), 16'(exp_d));
      chk({tag, ".flags"}, 16'({o_flag, z_flag, n_flag}), 16'(exp_f));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [M-1:0] adr, input logic [N-1:0] val);
      write = 1'b1; ie = 1'b1; waddr = adr; din = val; en = 1'b0;
      tick();
      write = 1'b0;
   endtask

   logic [N-1:0] lop_a  [4];
   logic [2:0]   lop_op [4];
   logic [N-1:0] lop_r  [4];
   logic [2:0]   lop_f  [4];

   initial begin
      din = '0; offset = '0; waddr = '0; ra = '0; rb = '0; op = OP_PASS;
      ie = 1'b0; write = 1'b0; reada = 1'b0; readb = 1'b0; en = 1'b0;
      oe = 1'b1; bypassa = 1'b0; bypassb = 1'b0;

      rst = 1'b1;
      #10;
      chk_out("reset", 8'h00, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      // read of any register after reset is zero
      reada = 1'b1; ra = 3'd5; op = OP_PASS; en = 1'b1;
      tick();
      chk_out("rd_after_rst", 8'h00, 3'b010);

      wr(3'd0, 8'h02);
      wr(3'd1, 8'h03);
      wr(3'd2, 8'h01);

      ra = 3'd0; rb = 3'd1; reada = 1'b1; readb = 1'b1; op = OP_ADD; en = 1'b1;
      tick();
      chk_out("add", 8'h05, 3'b000);

      bypassb = 1'b1; offset = 8'h20; op = OP_INC;
      tick();
      chk_out("inc", 8'h03, 3'b000);

      bypassb = 1'b0; bypassa = 1'b1; offset = 8'h55; op = OP_PASS;
      tick();
      chk_out("pass_imm", 8'h55, 3'b000);

      offset = 8'h7F; rb = 3'd2; op = OP_ADD;
      tick();
      chk_out("add_ovf", 8'h80, 3'b101);

      offset = 8'h80; op = OP_SUB;
      tick();
      chk_out("sub_ovf", 8'h7F, 3'b100);

      bypassa = 1'b0; ra = 3'd1; rb = 3'd1; op = OP_SUB;
      tick();
      chk_out("sub_zero", 8'h00, 3'b010);

      lop_a[0] = 8'hF0; lop_op[0] = OP_AND; lop_r[0] = 8'h00; lop_f[0] = 3'b010;
      lop_a[1] = 8'hF0; lop_op[1] = OP_OR;  lop_r[1] = 8'hF3; lop_f[1] = 3'b001;
      lop_a[2] = 8'hF1; lop_op[2] = OP_XOR; lop_r[2] = 8'hF2; lop_f[2] = 3'b001;
      lop_a[3] = 8'hF0; lop_op[3] = OP_NOT; lop_r[3] = 8'h0F; lop_f[3] = 3'b000;
      bypassa = 1'b1; rb = 3'd1;
      for (int i = 0; i < 4; i++) begin
         offset = lop_a[i]; op = lop_op[i];
         tick();
         chk_out($sformatf("logic%0d", i), lop_r[i], lop_f[i]);
      end

      offset = 8'h7F; op = OP_INC;
      tick();
      chk_out("inc_ovf", 8'h80, 3'b101);

      offset = 8'hFF; op = OP_INC;
      tick();
      chk_out("inc_wrap", 8'h00, 3'b010);

      offset = 8'h3C; op = OP_PASS;
      tick();
      chk_out("pre_hold", 8'h3C, 3'b000);

      en = 1'b0; offset = 8'h81;
      tick();
      chk_out("en_hold", 8'h3C, 3'b000);

      oe = 1'b0;
      #1;
      chk("oe_off", 16'(dout), 16'h0000);
      oe = 1'b1;
      #1;
      chk("oe_on", 16'(dout), 16'h003C);

      // writeback with ie=0 while en loads a new value: rf gets old result
      write = 1'b1; ie = 1'b0; waddr = 3'd4; en = 1'b1; offset = 8'h11;
      tick();
      write = 1'b0;
      chk_out("wb_same_cycle", 8'h11, 3'b000);
      bypassa = 1'b0; ra = 3'd4;
      tick();
      chk_out("wb_readback", 8'h3C, 3'b000);

      // write and read of one address in a cycle reads the old content
      ra = 3'd5; write = 1'b1; ie = 1'b1; waddr = 3'd5; din = 8'h99;
      tick();
      write = 1'b0;
      chk_out("rw_old", 8'h00, 3'b010);
      tick();
      chk_out("rw_new", 8'h99, 3'b001);

      reada = 1'b0;
      tick();
      chk_out("reada_off", 8'h00, 3'b010);

      reada = 1'b1; ra = 3'd1; op = OP_PASS;
      tick();
      chk_out("pre_rst", 8'h03, 3'b000);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 8'h00, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_out("rf_cleared", 8'h00, 3'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
